// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo: trigger-armed trace capture of a single-cycle CPU's
// retirement stream into a show-ahead FIFO, drained over valid/ready.
//
// Optional build macro: CPU_TRACE_TS_EN adds a free-running 32-bit cycle
// counter; each record stores its push-cycle value, exposed on out_ts.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc, instr, pcNext,       CPU observation inputs, sampled every cycle
//   aluResult, aluZero,
//   regWrite, branch, memWrite
//   arm, clear               control pulses (clear has priority)
//   trig_pc, cap_len         trigger address, records per capture (0 = unlimited)
//   out_valid/out_ready      head handshake; out_pc/instr/result/flags head fields
//   out_ts                   head timestamp (CPU_TRACE_TS_EN builds only)
//   level, drop_cnt, state   occupancy, saturating drop count, capture state
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | nothing recorded, waiting for arm
// ARMED | waiting for pc == trig_pc
// CAPTURE | pushing one record per cycle
// DONE  | capture length reached, FIFO retained
module cpu_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  input  logic [31:0]       pcNext,
  input  logic [31:0]       aluResult,
  input  logic              aluZero,
  input  logic              regWrite,
  input  logic              branch,
  input  logic              memWrite,
  input  logic              arm,
  input  logic              clear,
  input  logic [31:0]       trig_pc,
  input  logic [CNT_W-1:0]  cap_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_result,
  output logic [4:0]        out_flags,
`ifdef CPU_TRACE_TS_EN
  output logic [31:0]       out_ts,
`endif
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cap_cnt, cap_cnt_d, cap_next;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       mem_pc     [DEPTH];
  logic [31:0]       mem_instr  [DEPTH];
  logic [31:0]       mem_result [DEPTH];
  logic [4:0]        mem_flags  [DEPTH];
  logic taken, trig_hit, attempt, full, empty, pop, push, drop, cap_last;

  assign taken    = pcNext != (pc + 32'd4);
  assign full     = count == (ADDR_W+1)'(DEPTH);
  assign empty    = count == '0;
  assign pop      = !empty && out_ready && !clear;
  assign trig_hit = (state_q == ARMED) && (pc == trig_pc);
  assign attempt  = !clear && (trig_hit || state_q == CAPTURE);
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign push     = attempt && (!full || pop);
  assign drop     = attempt && full && !pop;
  assign cap_next = cap_cnt + CNT_W'(1);
  assign cap_last = (cap_len != '0) && (cap_next == cap_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap_cnt <= '0;
    end else begin
      state_q <= state_d;
      cap_cnt <= cap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_cnt_d = cap_cnt;
    if (clear) begin
      state_d   = IDLE;
      cap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d   = ARMED;
            cap_cnt_d = '0;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            cap_cnt_d = cap_next;
            state_d   = cap_last ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          cap_cnt_d = cap_next;
          if (cap_last) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Storage needs no reset: out_* are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]     <= pc;
      mem_instr[wr_ptr]  <= instr;
      mem_result[wr_ptr] <= aluResult;
      mem_flags[wr_ptr]  <= {taken, memWrite, branch, regWrite, aluZero};
    end
  end

  assign out_valid  = !empty;
  assign out_pc     = empty ? '0 : mem_pc[rd_ptr];
  assign out_instr  = empty ? '0 : mem_instr[rd_ptr];
  assign out_result = empty ? '0 : mem_result[rd_ptr];
  assign out_flags  = empty ? '0 : mem_flags[rd_ptr];
  assign level      = count;
  assign state      = state_q;

`ifdef CPU_TRACE_TS_EN
  logic [31:0] ts_cnt;
  logic [31:0] mem_ts [DEPTH];

  // Free-running; clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr] <= ts_cnt;
  end

  assign out_ts = empty ? '0 : mem_ts[rd_ptr];
`endif

endmodule

// File: tb/tb_cpu_trace_fifo.sv
module tb_cpu_trace_fifo;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc = '0, instr = '0, pcNext = '0, aluResult = '0, trig_pc = '0;
  logic aluZero = 0, regWrite = 0, branch = 0, memWrite = 0, arm = 0, clear = 0;
  logic [CNT_W-1:0] cap_len = '0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_pc, out_instr, out_result;
  logic [4:0] out_flags;
  logic [ADDR_W:0] level;
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .pcNext(pcNext),
    .aluResult(aluResult), .aluZero(aluZero), .regWrite(regWrite),
    .branch(branch), .memWrite(memWrite), .arm(arm), .clear(clear),
    .trig_pc(trig_pc), .cap_len(cap_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_result(out_result), .out_flags(out_flags), .level(level),
    .drop_cnt(drop_cnt), .state(state)
  );

  // Reference model: a queue of records plus capture bookkeeping.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] res;
    logic [4:0]  flags;
  } rec_t;

  rec_t q[$];
  int m_st = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  int m_drop = 0;

  task automatic model_reset();
    q.delete();
    m_st = 0;
    m_cnt = '0;
    m_drop = 0;
  endtask

  task automatic model_step();
    rec_t r;
    bit att, pop;
    if (clear) begin
      model_reset();
      return;
    end
    pop = (q.size() > 0) && out_ready;
    att = (m_st == 1 && pc == trig_pc) || m_st == 2;
    if (pop) void'(q.pop_front());
    if (att) begin
      r.pc = pc;
      r.instr = instr;
      r.res = aluResult;
      r.flags = {(pcNext != pc + 32'd4), memWrite, branch, regWrite, aluZero};
      if (q.size() < DEPTH) q.push_back(r);
      else if (m_drop < 255) m_drop++;
      m_cnt = m_cnt + 8'd1;
      m_st = (cap_len != 0 && m_cnt == cap_len) ? 3 : 2;
    end else if (arm && (m_st == 0 || m_st == 3)) begin
      m_st = 1;
      m_cnt = '0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc = p;
    pcNext = p + 32'd4;
    instr = p ^ 32'hA5A5_0F0F;
    aluResult = p + 32'h1000;
    aluZero = 0; regWrite = 0; branch = 0; memWrite = 0;
  endtask

  task automatic do_reset();
    arm = 0; clear = 0; out_ready = 0;
    set_pc(32'h0);
    rst = 1;
    @(posedge clk); @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'd0 || level !== 5'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_status: state=%0d level=%0d valid=%0b drop=%0d, want 0/0/0/0",
               state, level, out_valid, drop_cnt);
    end
    checks++;
    if (out_pc !== 0 || out_instr !== 0 || out_result !== 0 || out_flags !== 0) begin
      errors++;
      $display("FAIL reset_data: pc=%h instr=%h res=%h flags=%b, want all zero",
               out_pc, out_instr, out_result, out_flags);
    end
  endtask

  task automatic test_trigger();
    logic [31:0] exp_pcs [3];
    logic [1:0] exp_st [5];
    exp_pcs[0] = 32'h8; exp_pcs[1] = 32'hC; exp_pcs[2] = 32'h10;
    exp_st[0] = 1; exp_st[1] = 1; exp_st[2] = 2; exp_st[3] = 2; exp_st[4] = 3;
    do_reset();
    trig_pc = 32'h8; cap_len = 8'd3;
    arm = 1; cycle(); arm = 0;
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL trig_armed: state=%0d want 1", state);
    end
    for (int i = 0; i < 5; i++) begin
      set_pc(32'(i * 4));
      cycle();
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL trig_state[%0d]: state=%0d want %0d", i, state, exp_st[i]);
      end
    end
    checks++;
    if (level !== 5'd3) begin
      errors++; $display("FAIL trig_level: level=%0d want 3", level);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pcs[i]) begin
        errors++; $display("FAIL trig_drain[%0d]: valid=%0b pc=%h want 1/%h", i, out_valid, out_pc, exp_pcs[i]);
      end
      cycle();
    end
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL trig_empty: level=%0d valid=%0b want 0/0", level, out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_flags();
    do_reset();
    trig_pc = 32'h20; cap_len = 8'd2;
    arm = 1; cycle(); arm = 0;
    set_pc(32'h20); pcNext = 32'h40; branch = 1; aluZero = 1;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_flags !== 5'b10101) begin
      errors++; $display("FAIL flags_taken: valid=%0b flags=%b want 1/10101", out_valid, out_flags);
    end
    set_pc(32'h24); regWrite = 1;
    cycle();
    set_pc(32'h0);
    out_ready = 1;
    cycle();
    checks++;
    if (out_flags !== 5'b00010 || out_pc !== 32'h24) begin
      errors++; $display("FAIL flags_regwrite: pc=%h flags=%b want 24/00010", out_pc, out_flags);
    end
    out_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    trig_pc = 32'h100; cap_len = 8'd0;
    arm = 1; cycle(); arm = 0;
    for (int i = 0; i < 20; i++) begin
      set_pc(32'h100 + 32'(i * 4));
      cycle();
    end
    checks++;
    if (level !== 5'd16 || drop_cnt !== 8'd4) begin
      errors++; $display("FAIL overflow: level=%0d drop=%0d want 16/4", level, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    int bad = 0;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      if (out_pc !== 32'h100 + 32'(i * 4)) begin
        bad++;
        $display("FAIL full_order[%0d]: pc=%h want %h", i, out_pc, 32'h100 + 32'(i * 4));
      end
      set_pc(32'h150 + 32'(i * 4));
      cycle();
      if (level !== 5'd16 || drop_cnt !== 8'd4) begin
        bad++;
        $display("FAIL full_level[%0d]: level=%0d drop=%0d want 16/4", i, level, drop_cnt);
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (out_pc !== 32'h150) begin
      errors++; $display("FAIL full_after: pc=%h want 150", out_pc);
    end
    out_ready = 0;
  endtask

  task automatic test_clear_mid();
    do_reset();
    trig_pc = 32'h0; cap_len = 8'd0;
    arm = 1; cycle(); arm = 0;
    for (int i = 0; i < 5; i++) begin
      set_pc(32'(i * 4));
      cycle();
    end
    checks++;
    if (level !== 5'd5 || state !== 2'd2) begin
      errors++; $display("FAIL clear_pre: level=%0d state=%0d want 5/2", level, state);
    end
    out_ready = 1; arm = 1; clear = 1;
    cycle();
    clear = 0; arm = 0; out_ready = 0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || state !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL clear_post: level=%0d valid=%0b state=%0d drop=%0d want 0/0/0/0",
                         level, out_valid, state, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    trig_pc = 32'h0; cap_len = 8'd0;
    arm = 1; cycle(); arm = 0;
    for (int i = 0; i < 4; i++) begin
      set_pc(32'(i * 4));
      cycle();
    end
    #3 rst = 1;
    #1;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || state !== 2'd0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL async_reset: level=%0d valid=%0b state=%0d pc=%h want 0/0/0/0",
                         level, out_valid, state, out_pc);
    end
    #1 rst = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_rearm();
    logic [31:0] exp_pcs [4];
    exp_pcs[0] = 32'h200; exp_pcs[1] = 32'h204; exp_pcs[2] = 32'h300; exp_pcs[3] = 32'h304;
    do_reset();
    trig_pc = 32'h200; cap_len = 8'd2;
    arm = 1; cycle(); arm = 0;
    set_pc(32'h200); cycle();
    set_pc(32'h204); cycle();
    checks++;
    if (state !== 2'd3 || level !== 5'd2) begin
      errors++; $display("FAIL rearm_done: state=%0d level=%0d want 3/2", state, level);
    end
    trig_pc = 32'h300;
    set_pc(32'h208);
    arm = 1; cycle(); arm = 0;
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL rearm_armed: state=%0d want 1", state);
    end
    set_pc(32'h300); cycle();
    set_pc(32'h304); cycle();
    checks++;
    if (state !== 2'd3 || level !== 5'd4) begin
      errors++; $display("FAIL rearm_level: state=%0d level=%0d want 3/4", state, level);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_pc !== exp_pcs[i]) begin
        errors++; $display("FAIL rearm_drain[%0d]: pc=%h want %h", i, out_pc, exp_pcs[i]);
      end
      cycle();
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] lens [4];
    lens[0] = 8'd0; lens[1] = 8'd1; lens[2] = 8'd3; lens[3] = 8'd20;
    for (int s = 0; s < 4; s++) begin
      do_reset();
      trig_pc = 32'h40;
      cap_len = lens[s];
      for (int n = 0; n < 400; n++) begin
        pc = ($urandom_range(0, 7) == 0) ? trig_pc : 32'($urandom_range(0, 63)) << 2;
        pcNext = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : $urandom;
        instr = $urandom;
        aluResult = $urandom;
        {aluZero, regWrite, branch, memWrite} = 4'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        arm = ($urandom_range(0, 9) == 0);
        clear = ($urandom_range(0, 59) == 0);
        cycle();
        checks++;
        if (state !== 2'(m_st) || level !== 5'(q.size()) || drop_cnt !== 8'(m_drop)
            || out_valid !== (q.size() != 0)) begin
          errors++;
          $display("FAIL rand_status[%0d/%0d]: state=%0d level=%0d drop=%0d valid=%0b want %0d/%0d/%0d/%0b",
                   s, n, state, level, drop_cnt, out_valid, m_st, q.size(), m_drop, q.size() != 0);
        end
        if (q.size() != 0) begin
          checks++;
          if (out_pc !== q[0].pc || out_instr !== q[0].instr || out_result !== q[0].res
              || out_flags !== q[0].flags) begin
            errors++;
            $display("FAIL rand_head[%0d/%0d]: pc=%h instr=%h res=%h flags=%b want %h/%h/%h/%b",
                     s, n, out_pc, out_instr, out_result, out_flags,
                     q[0].pc, q[0].instr, q[0].res, q[0].flags);
          end
        end
      end
      arm = 0; clear = 0;
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_flags();
    test_overflow();
    test_full_push_pop();
    test_clear_mid();
    test_reset_mid();
    test_rearm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_fifo.md
Name: cpu_trace_fifo

Overview:
- Downstream consumer of the single-cycle CPU's observation outputs (pc, instr, pcNext, aluResult and control flags).
- Arms, waits for a trigger PC, then records one entry per retired instruction into an internal FIFO.
- Drains the FIFO over a valid/ready interface to a trace sink (UART bridge or bench scoreboard).
- One instruction retires per clk, so a record is offered every cycle while capturing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ADDR_W, 4, log2(DEPTH); caller keeps it consistent with DEPTH.
- CNT_W, 8, width of drop counter and capture-length counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  CPU current PC.
- instr  in  32  CPU current instruction.
- pcNext  in  32  CPU next PC.
- aluResult  in  32  CPU ALU result.
- aluZero  in  1  CPU ALU zero flag.
- regWrite  in  1  CPU control flag.
- branch  in  1  CPU control flag.
- memWrite  in  1  CPU control flag.
- arm  in  1  single-cycle pulse; starts waiting for the trigger.
- clear  in  1  single-cycle pulse; flushes the FIFO and returns to IDLE.
- trig_pc  in  32  trigger address.
- cap_len  in  CNT_W  records to capture after the trigger; 0 = unlimited.
- out_valid  out  1  head entry valid.
- out_ready  in  1  sink accepts head entry.
- out_pc  out  32  head entry field.
- out_instr  out  32  head entry field.
- out_result  out  32  head entry field.
- out_flags  out  5  head entry {taken, memWrite, branch, regWrite, aluZero}.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- drop_cnt  out  CNT_W  records lost to a full FIFO; saturates at all-ones.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Behaviour:
- Reset: state=IDLE, FIFO empty, level=0, out_valid=0, drop_cnt=0, capture counter=0. out_* data fields are 0.
- Record content:
  - {pc, instr, aluResult}.
  - flags = {taken, memWrite, branch, regWrite, aluZero}.
  - taken = (pcNext != pc+4), modulo-2^32 add; pc=FFFFFFFC with pcNext=0 gives taken=0.
- Transitions:
  - IDLE: arm -> ARMED. Nothing is recorded.
  - ARMED: a cycle with pc==trig_pc -> CAPTURE, and that cycle's record is pushed.
  - CAPTURE: push the current record every cycle. The capture counter counts push attempts, including dropped ones. When the count reaches cap_len (cap_len != 0) -> DONE; the cap_len-th record is the last one pushed.
  - DONE: no pushes. arm -> ARMED; FIFO contents and drop_cnt are retained, the capture counter is cleared.
- clear: has priority over arm and over any push in the same cycle. It empties the FIFO, zeroes drop_cnt and the capture counter, and sets state=IDLE. A pop in the same cycle is discarded.
- arm while in ARMED or CAPTURE is ignored.
- FIFO:
  - Show-ahead: out_* reflect the head entry while out_valid=1.
  - Pop occurs when out_valid && out_ready.
  - Push-to-visible latency: 1 cycle. A push into an empty FIFO gives out_valid=1 on the next cycle.
  - Full, push and pop in the same cycle: the push is accepted and level stays DEPTH.
  - Full, push and no pop: the record is dropped and drop_cnt increments (saturating).
  - Empty with out_ready high: no effect.
  - Pointers wrap modulo DEPTH.
- The trigger compare uses live inputs with no pipeline delay.
- rst asserted mid-capture immediately clears all state; no partial entry survives.

Optional Feature:
- Macro: CPU_TRACE_TS_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0 and wrapping.
  - Each record also stores the counter value at its push cycle, exposed on extra port out_ts (out, 32).
  - clear does not reset the counter.
- Undefined: no counter, no out_ts port, record width unchanged.

Test Plan:
- Trigger capture:
  - Stimulus: reset; arm; trig_pc=0x00000008; pc steps 0,4,8,C,10; cap_len=3; out_ready=0.
  - Required: state 1 after arm, 2 at pc=8, 3 after pc=10; level=3.
  - Drained entries have pc = 8, C, 10.
- Flags:
  - Stimulus: at pc=0x20, pcNext=0x40, branch=1, aluZero=1.
  - Required: out_flags=5'b10101.
  - Stimulus: pc=0x24, pcNext=0x28, regWrite=1.
  - Required: out_flags=5'b00010.
- Overflow:
  - Stimulus: DEPTH=16, cap_len=0, out_ready=0 for 20 captured cycles.
  - Required: level=16, drop_cnt=4.
  - Then stream with out_ready=1: entries are the first 16 pcs in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_ready=1, capture continuing.
  - Required: level stays 16, drop_cnt unchanged, and entries come out in order.
- Clear and reset mid-capture:
  - Stimulus: clear while level=5 in CAPTURE.
  - Required: next cycle level=0, out_valid=0, state=0.
  - Stimulus: rst pulse mid-capture.
  - Required: same result, asserted asynchronously before the next clock edge.
- Re-arm from DONE:
  - Stimulus: from DONE with level=2, arm, trigger hits, cap_len=2.
  - Required: level=4; the original 2 entries drain first.
